// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default geometry plus binary/Gray conversion.
// The read-side pointer block imports this package too, so both domains
// encode and decode pointers identically.
package fifo_pkg;

  localparam int DEFAULT_ADDRESS_SIZE      = 4;
  localparam int DEFAULT_ALMOST_FULL_LEVEL = 14;

  // Conversions work on a wide word; callers zero-extend their pointer in
  // and truncate the result back to pointer width. Zero upper bits leave
  // both conversions unaffected.
  localparam int PTR_FN_W = 32;
  typedef logic [PTR_FN_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin_to_gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray_to_bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_FN_W-1] = gray[PTR_FN_W-1];
    for (int i = PTR_FN_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side pointer/flag bundle between the producer, the write-pointer
// block and the dual-clock RAM. The slave modport is the pointer block.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
);

  logic                    w_en;
  logic [ADDRESS_SIZE:0]   r_ptr_gray;
  logic [ADDRESS_SIZE-1:0] w_adrs;
  logic [ADDRESS_SIZE:0]   w_ptr_gray;
  logic                    full;
  logic                    almost_full;
  logic [ADDRESS_SIZE:0]   w_count;
  logic                    overflow;

  modport master (
    output w_en, r_ptr_gray,
    input  w_adrs, w_ptr_gray, full, almost_full, w_count, overflow
  );

  modport slave (
    input  w_en, r_ptr_gray,
    output w_adrs, w_ptr_gray, full, almost_full, w_count, overflow
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into this clock.
// Only one bit changes per source update, so per-bit capture is coherent.
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two capture stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag logic of an asynchronous FIFO.
// Keeps the binary/Gray write pointers, synchronizes the read pointer, and
// produces registered full, almost_full, occupancy and sticky overflow.
// full is pessimistic: it can only clear once the synchronized read pointer
// has moved, never earlier. ADDRESS_SIZE must be at least 2.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE      = DEFAULT_ADDRESS_SIZE,
  parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL_LEVEL
) (
  input  logic           w_clk,
  input  logic           reset,
  fifo_wptr_full_if.slave bus
);

  localparam int PTR_W = ADDRESS_SIZE + 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(ALMOST_FULL_LEVEL);

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gray;
  logic             r_full;
  logic             r_almost_full;
  logic [PTR_W-1:0] r_count;
  logic             r_overflow;

  logic             w_accept;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic [PTR_W-1:0] w_rptr_sync;
  logic [PTR_W-1:0] w_rptr_bin;
  logic [PTR_W-1:0] w_full_target;
  logic             w_full_next;
  logic [PTR_W-1:0] w_count_next;
  logic             w_almost_full_next;

  // Read pointer enters this domain only through the synchronizer.
  sync_2ff #(
    .WIDTH(PTR_W)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (reset),
    .i_d (bus.r_ptr_gray),
    .o_q (w_rptr_sync)
  );

  // A write is taken only while not full; this is also the RAM write enable.
  assign w_accept    = bus.w_en & ~r_full;
  assign w_bin_next  = r_bin + PTR_W'(w_accept);
  assign w_gray_next = PTR_W'(bin_to_gray(ptr_word_t'(w_bin_next)));
  assign w_rptr_bin  = PTR_W'(gray_to_bin(ptr_word_t'(w_rptr_sync)));

  // Full when the writer is one lap ahead: in Gray code that is the read
  // pointer with its two MSBs inverted and all other bits equal.
  assign w_full_target      = {~w_rptr_sync[PTR_W-1:PTR_W-2], w_rptr_sync[PTR_W-3:0]};
  assign w_full_next        = (w_gray_next == w_full_target);
  assign w_count_next       = w_bin_next - w_rptr_bin;
  assign w_almost_full_next = (w_count_next >= AF_LEVEL);

  // Pointer, flag and occupancy registers, all advancing on the same edge.
  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      r_bin         <= '0;
      r_gray        <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_bin         <= w_bin_next;
      r_gray        <= w_gray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_count       <= w_count_next;
      if (bus.w_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.w_adrs      = r_bin[ADDRESS_SIZE-1:0];
  assign bus.w_ptr_gray  = r_gray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.w_count     = r_count;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDRESS_SIZE=4, ALMOST_FULL_LEVEL=14).
// A cycle-level occupancy model (write count vs. read index seen two edges
// late) is compared against the DUT every cycle; directed steps add literal
// expectations for the scenarios of interest.
module tb_fifo_wptr_full;

  logic w_clk;
  logic reset;
  int   checks;
  int   failures;
  bit   cmp_on;

  fifo_wptr_full_if #(.ADDRESS_SIZE(4)) bus ();

  fifo_wptr_full #(
    .ADDRESS_SIZE      (4),
    .ALMOST_FULL_LEVEL (14)
  ) dut (
    .w_clk (w_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  // Decode by search: which index 0..31 has this Gray code.
  function automatic int index_of_gray(input int g);
    for (int i = 0; i < 32; i++) begin
      if (gray_of(i) == g) return i;
    end
    return -1;
  endfunction

  function automatic int occ(input int wr, input int rd);
    return (wr - rd + 32) % 32;
  endfunction

  int m_wr;     // accepted writes mod 32
  int m_cnt;
  bit m_full;
  bit m_af;
  bit m_ovf;
  int r_prev1;  // r_ptr_gray seen at previous edge
  int r_prev2;  // r_ptr_gray seen two edges ago

  always @(posedge w_clk or posedge reset) begin
    if (reset) begin
      m_wr    <= 0;
      m_cnt   <= 0;
      m_full  <= 1'b0;
      m_af    <= 1'b0;
      m_ovf   <= 1'b0;
      r_prev1 <= 0;
      r_prev2 <= 0;
    end else begin
      m_wr    <= (m_wr + ((bus.w_en && !m_full) ? 1 : 0)) % 32;
      m_cnt   <= occ((m_wr + ((bus.w_en && !m_full) ? 1 : 0)) % 32, index_of_gray(r_prev2));
      m_full  <= occ((m_wr + ((bus.w_en && !m_full) ? 1 : 0)) % 32, index_of_gray(r_prev2)) == 16;
      m_af    <= occ((m_wr + ((bus.w_en && !m_full) ? 1 : 0)) % 32, index_of_gray(r_prev2)) >= 14;
      m_ovf   <= m_ovf || (bus.w_en && m_full);
      r_prev2 <= r_prev1;
      r_prev1 <= int'(bus.r_ptr_gray);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge w_clk) begin
    if (cmp_on && !reset) begin
      chk("m_adrs",  int'(bus.w_adrs),      m_wr % 16);
      chk("m_gray",  int'(bus.w_ptr_gray),  gray_of(m_wr));
      chk("m_full",  int'(bus.full),        int'(m_full));
      chk("m_af",    int'(bus.almost_full), int'(m_af));
      chk("m_count", int'(bus.w_count),     m_cnt);
      chk("m_ovf",   int'(bus.overflow),    int'(m_ovf));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic edge_step();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    reset = 1'b1;
    bus.w_en = 1'b0;
    bus.r_ptr_gray = '0;
    edge_step();
    edge_step();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_adrs"},  int'(bus.w_adrs),      0);
    chk({tag, "_gray"},  int'(bus.w_ptr_gray),  0);
    chk({tag, "_full"},  int'(bus.full),        0);
    chk({tag, "_af"},    int'(bus.almost_full), 0);
    chk({tag, "_count"}, int'(bus.w_count),     0);
    chk({tag, "_ovf"},   int'(bus.overflow),    0);
  endtask

  int prev_gray;
  int seen_full;

  initial begin
    checks   = 0;
    failures = 0;
    cmp_on   = 1'b0;
    reset    = 1'b1;
    bus.w_en = 1'b0;
    bus.r_ptr_gray = '0;
    #1;
    check_all_zero("async_rst");
    do_reset();
    cmp_on = 1'b1;
    check_all_zero("rst");

    // Fill 16 writes with the reader idle.
    bus.w_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("fill_adrs_pre", int'(bus.w_adrs), i - 1);
      edge_step();
      chk("fill_count", int'(bus.w_count), i);
      chk("fill_af", int'(bus.almost_full), (i >= 14) ? 1 : 0);
      chk("fill_full", int'(bus.full), (i == 16) ? 1 : 0);
    end

    // Write while full: pointers frozen, overflow sticks.
    edge_step();
    chk("ovf_adrs", int'(bus.w_adrs), 0);
    chk("ovf_gray", int'(bus.w_ptr_gray), 24);
    chk("ovf_set", int'(bus.overflow), 1);
    bus.w_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      edge_step();
      chk("ovf_hold", int'(bus.overflow), 1);
    end

    // Reader frees one slot: full clears on the third edge.
    bus.r_ptr_gray = 5'b00001;
    edge_step();
    chk("rd_full_e1", int'(bus.full), 1);
    edge_step();
    chk("rd_full_e2", int'(bus.full), 1);
    edge_step();
    chk("rd_full_e3", int'(bus.full), 0);
    chk("rd_count_e3", int'(bus.w_count), 15);

    // Reader tracking writer for 32 writes.
    do_reset();
    bus.w_en = 1'b1;
    prev_gray = 0;
    seen_full = 0;
    for (int k = 0; k < 32; k++) begin
      bus.r_ptr_gray = 5'(gray_of(k));
      edge_step();
      chk("trk_hamming", $countones(5'(prev_gray) ^ bus.w_ptr_gray), 1);
      if (bus.full) seen_full = 1;
      if (k == 30) chk("trk_gray_31", int'(bus.w_ptr_gray), 16);
      prev_gray = int'(bus.w_ptr_gray);
    end
    chk("trk_gray_32", int'(bus.w_ptr_gray), 0);
    chk("trk_never_full", seen_full, 0);

    // Async reset pulse between edges with five entries stored.
    bus.r_ptr_gray = '0;
    do_reset();
    bus.w_en = 1'b1;
    for (int i = 0; i < 5; i++) edge_step();
    chk("mid_count", int'(bus.w_count), 5);
    bus.w_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    reset = 1'b0;
    bus.w_en = 1'b1;
    edge_step();
    chk("mid_adrs_after", int'(bus.w_adrs), 1);
    chk("mid_count_after", int'(bus.w_count), 1);

    // Last write coinciding with a read-pointer advance.
    do_reset();
    bus.w_en = 1'b1;
    for (int i = 0; i < 15; i++) edge_step();
    chk("sim_count15", int'(bus.w_count), 15);
    bus.r_ptr_gray = 5'b00001;
    edge_step();
    bus.w_en = 1'b0;
    chk("sim_full_a", int'(bus.full), 1);
    edge_step();
    chk("sim_full_b", int'(bus.full), 1);
    edge_step();
    chk("sim_full_c", int'(bus.full), 0);
    chk("sim_count_c", int'(bus.w_count), 15);

    edge_step();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
